// File: rtl/btb_update_gen_pkg.sv
// Shared types for the BTB update generator: address width, the update packet
// handed to the frontend BTB, and the FIFO entry format.
package btb_update_gen_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
    } btb_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/btb_update_fifo.sv
// DEPTH-entry FIFO of pending BTB updates; besides push/pop it can rewrite the
// target of the newest entry so the parent can coalesce repeated PCs.
module btb_update_fifo
    import btb_update_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  btb_entry_t       push_data_i,
    input  logic             pop_i,
    input  logic             wr_newest_i,
    input  logic [VLEN-1:0]  newest_target_i,
    output btb_entry_t       head_o,
    output logic [VLEN-1:0]  newest_pc_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    btb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] newest_ptr;

    assign newest_ptr  = wr_ptr - PTR_W'(1);
    assign head_o      = mem[rd_ptr];
    assign newest_pc_o = mem[newest_ptr].pc;

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            if (push_i) begin
                mem[wr_ptr] <= push_data_i;
            end else if (wr_newest_i) begin
                mem[newest_ptr].target <= newest_target_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else if (clr_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_gen.sv
// Collects resolved indirect-jump mispredictions, coalesces repeats of the same
// PC, and drains them one per granted cycle as single-cycle BTB update pulses.
module btb_update_gen
    import btb_update_gen_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  flush_i,
    input  logic                  debug_mode_i,
    input  logic                  resolve_valid_i,
    input  logic                  resolve_is_indirect_i,
    input  logic                  resolve_mispredict_i,
    input  logic [VLEN-1:0]       resolve_pc_i,
    input  logic [VLEN-1:0]       resolve_target_i,
    input  logic                  update_ready_i,
    output btb_update_t           btb_update_o,
    output logic                  pending_o,
    output logic                  full_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned BTB_UPDATE_CNT_W = $clog2(DEPTH) + 1;

    logic                        capture;
    logic                        pop;
    logic                        coalesce;
    logic                        enqueue;
    logic                        drop;
    logic                        fifo_clr;
    logic [BTB_UPDATE_CNT_W-1:0] count;
    btb_entry_t                  head;
    btb_entry_t                  new_entry;
    logic [VLEN-1:0]             newest_pc;

    assign fifo_clr  = flush_i | clr_i;
    assign pending_o = (count != '0);
    assign full_o    = (count == BTB_UPDATE_CNT_W'(DEPTH));

    assign capture = resolve_valid_i & resolve_is_indirect_i & resolve_mispredict_i
                   & ~debug_mode_i & ~fifo_clr;
    assign pop     = pending_o & update_ready_i & ~fifo_clr;

    // A lone entry that is leaving this cycle cannot absorb the new target.
    assign coalesce = capture & pending_o & (resolve_pc_i == newest_pc)
                    & ~((count == BTB_UPDATE_CNT_W'(1)) & pop);
    assign enqueue  = capture & ~coalesce & (~full_o | pop);
    assign drop     = capture & ~coalesce & full_o & ~pop;

    assign new_entry.pc     = resolve_pc_i;
    assign new_entry.target = resolve_target_i;

    btb_update_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (BTB_UPDATE_CNT_W)
    ) u_fifo (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clr_i           (fifo_clr),
        .push_i          (enqueue),
        .push_data_i     (new_entry),
        .pop_i           (pop),
        .wr_newest_i     (coalesce),
        .newest_target_i (resolve_target_i),
        .head_o          (head),
        .newest_pc_o     (newest_pc),
        .count_o         (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btb_update_o <= '0;
        end else begin
            btb_update_o.valid <= pop;
            if (pop) begin
                btb_update_o.pc             <= head.pc;
                btb_update_o.target_address <= head.target;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (clr_i) begin
            drop_cnt_o <= '0;
        end else if (drop && !(&drop_cnt_o)) begin
            drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_update_gen.sv
// Directed and randomized checks of btb_update_gen against a queue-based model.
module tb_btb_update_gen;
    import btb_update_gen_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clr_i, flush_i, debug_mode_i;
    logic            rv, ri, rm, ready;
    logic [VLEN-1:0] rpc, rtgt;
    btb_update_t     upd;
    logic            pending, full;
    logic [DW-1:0]   drop;

    btb_update_gen #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .clr_i                 (clr_i),
        .flush_i               (flush_i),
        .debug_mode_i          (debug_mode_i),
        .resolve_valid_i       (rv),
        .resolve_is_indirect_i (ri),
        .resolve_mispredict_i  (rm),
        .resolve_pc_i          (rpc),
        .resolve_target_i      (rtgt),
        .update_ready_i        (ready),
        .btb_update_o          (upd),
        .pending_o             (pending),
        .full_o                (full),
        .drop_cnt_o            (drop)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] tgt;
    } ent_t;

    ent_t            q[$];
    logic            m_valid;
    logic [VLEN-1:0] m_pc, m_tgt;
    int              m_drop;
    int              passed = 0;
    int              total  = 0;
    int              failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_pc    = '0;
        m_tgt   = '0;
        m_drop  = 0;
    endtask

    // One clock of the rules: flush/clear wipe, head leaves on grant,
    // a repeated PC overwrites the newest target, a full queue drops.
    task automatic model_step();
        bit cap, pop, merge;
        ent_t e;
        cap = rv && ri && rm && !debug_mode_i && !flush_i && !clr_i;
        pop = (q.size() > 0) && ready && !flush_i && !clr_i;
        if (flush_i || clr_i) begin
            q.delete();
            m_valid = 1'b0;
            if (clr_i) m_drop = 0;
        end else begin
            m_valid = pop;
            if (pop) begin
                m_pc  = q[0].pc;
                m_tgt = q[0].tgt;
            end
            if (cap) begin
                merge = (q.size() > 0) && (q[q.size()-1].pc == rpc) && !(q.size() == 1 && pop);
                if (merge) begin
                    q[q.size()-1].tgt = rtgt;
                end else if (q.size() < DEPTH || pop) begin
                    e.pc  = rpc;
                    e.tgt = rtgt;
                    q.push_back(e);
                end else if (m_drop < (1 << DW) - 1) begin
                    m_drop++;
                end
            end
            if (pop) void'(q.pop_front());
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(upd.valid), 64'(m_valid));
        chk("pc", upd.pc, m_pc);
        chk("target", upd.target_address, m_tgt);
        chk("pending", 64'(pending), 64'(q.size() != 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("drop_cnt", 64'(drop), 64'(m_drop));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic cap(input logic [VLEN-1:0] pc, input logic [VLEN-1:0] tgt);
        rv = 1'b1; ri = 1'b1; rm = 1'b1;
        rpc = pc; rtgt = tgt;
    endtask

    task automatic idle();
        rv = 1'b0; ri = 1'b0; rm = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clr_i = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0;
        ready = 1'b0; rpc = '0; rtgt = '0;
        idle();
        model_reset();
        #12;
        check_all();
        #5 rst_ni = 1'b1;

        // single capture: pending in cycle 1, pulse in cycle 2
        ready = 1'b1;
        cap(64'h8000_0010, 64'h8000_0400);
        tick();
        idle();
        chk("single_pending_c1", 64'(pending), 64'd1);
        tick();
        chk("single_valid_c2", 64'(upd.valid), 64'd1);
        chk("single_pc", upd.pc, 64'h8000_0010);
        chk("single_tgt", upd.target_address, 64'h8000_0400);
        tick();
        chk("single_valid_c3", 64'(upd.valid), 64'd0);

        // coalesce
        ready = 1'b0;
        cap(64'h100, 64'h200); tick();
        cap(64'h100, 64'h300); tick();
        idle(); tick();
        ready = 1'b1; tick();
        chk("coal_pending_after_pop", 64'(pending), 64'd0);
        chk("coal_tgt", upd.target_address, 64'h300);
        tick();

        // overflow then full plus pop
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cap(64'(i * 16), 64'h1000 + 64'(i)); tick();
        end
        idle(); tick();
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_drop", 64'(drop), 64'd1);
        ready = 1'b1;
        cap(64'h60, 64'h1060); tick();
        chk("fullpop_drop", 64'(drop), 64'd1);
        chk("fullpop_full", 64'(full), 64'd1);
        idle();
        tick();
        chk("ovf_second_pc", upd.pc, 64'h20);
        for (int i = 0; i < 5; i++) tick();

        // flush on the cycle of the first pop
        ready = 1'b0;
        cap(64'h70, 64'h700); tick();
        cap(64'h80, 64'h800); tick();
        cap(64'h90, 64'h900); tick();
        idle(); ready = 1'b1; flush_i = 1'b1; tick();
        flush_i = 1'b0;
        chk("flush_valid", 64'(upd.valid), 64'd0);
        chk("flush_pending", 64'(pending), 64'd0);
        cap(64'hA0, 64'hA00); tick();
        idle(); tick(); tick();

        // filtering
        debug_mode_i = 1'b1; cap(64'hB0, 64'hB00); tick();
        debug_mode_i = 1'b0; cap(64'hB0, 64'hB00); rm = 1'b0; tick();
        cap(64'hB0, 64'hB00); ri = 1'b0; tick();
        idle();
        chk("filter_pending", 64'(pending), 64'd0);

        // clear wipes the drop counter
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cap(64'h200 + 64'(i * 4), 64'h5000); tick();
        end
        idle(); clr_i = 1'b1; tick();
        clr_i = 1'b0;
        chk("clr_drop", 64'(drop), 64'd0);

        // randomized traffic on a small PC set to exercise coalescing
        for (int n = 0; n < 600; n++) begin
            rv   = ($urandom_range(0, 3) != 0);
            ri   = ($urandom_range(0, 7) != 0);
            rm   = ($urandom_range(0, 7) != 0);
            rpc  = 64'h4000 + 64'($urandom_range(0, 3) * 4);
            rtgt = {32'h0, $urandom};
            ready        = ($urandom_range(0, 9) < 4);
            debug_mode_i = ($urandom_range(0, 15) == 0);
            flush_i      = ($urandom_range(0, 39) == 0);
            clr_i        = ($urandom_range(0, 79) == 0);
            tick();
        end
        flush_i = 1'b0; clr_i = 1'b0; debug_mode_i = 1'b0;

        // asynchronous reset mid-drain
        ready = 1'b0;
        cap(64'hC0, 64'hC00); tick();
        cap(64'hD0, 64'hD00); tick();
        cap(64'hE0, 64'hE00); tick();
        idle(); ready = 1'b1; tick(); tick();
        #3 rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(upd.valid), 64'd0);
        chk("rst_pc", upd.pc, 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        #2 rst_ni = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/btb_update_gen.md
Name: btb_update_gen

Overview:
- Backend-side producer of BTB update packets (btb_update_t) for the frontend BTB.
- Captures resolved indirect-jump mispredictions from the branch unit and buffers them in a small FIFO, coalescing back-to-back updates to the same PC.
- Drains at most one entry per cycle as a single-cycle update pulse, only when the frontend grants the update slot.
- Discards pending updates on flush/clear so stale targets never reach a freshly invalidated BTB.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- DROP_CNT_W, 8, width of the saturating overflow-drop counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- clr_i  in  1  synchronous clear, active high
- flush_i  in  1  discard all pending updates (same event that flushes the BTB)
- debug_mode_i  in  1  suppress new captures while in debug mode
- resolve_valid_i  in  1  branch unit resolved a control-flow instruction this cycle
- resolve_is_indirect_i  in  1  resolved instruction is a JALR-type indirect jump
- resolve_mispredict_i  in  1  predicted target differed from resolved target
- resolve_pc_i  in  riscv::VLEN  PC of resolved instruction
- resolve_target_i  in  riscv::VLEN  resolved target address
- update_ready_i  in  1  frontend accepts a BTB write this cycle; low during fetch redirect
- btb_update_o  out  ariane_pkg::btb_update_t  {valid, pc, target_address} to the BTB
- pending_o  out  1  FIFO non-empty
- full_o  out  1  count == DEPTH
- drop_cnt_o  out  DROP_CNT_W  saturating count of updates lost to overflow

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FIFO empty, read/write pointers 0.
  - btb_update_o all zero (valid=0).
  - pending_o=0, full_o=0, drop_cnt_o=0.
- capture = resolve_valid_i & resolve_is_indirect_i & resolve_mispredict_i & !debug_mode_i & !flush_i & !clr_i.
- pop = pending_o & update_ready_i & !flush_i & !clr_i.
- Output register, updated every cycle:
  - btb_update_o.valid <= pop.
  - On pop, pc/target_address are loaded from the head entry.
  - Otherwise pc/target_address hold their value; only valid drops.
  - Each entry therefore appears as exactly one one-cycle valid pulse.
- Latency: with an empty FIFO and update_ready_i high, a capture in cycle t gives btb_update_o.valid=1 in cycle t+2 (t+1: entry in FIFO; pop at the end of t+1).
- Coalescing: if capture and the FIFO is non-empty and resolve_pc_i equals the newest entry's PC (full VLEN compare):
  - The newest entry's target is overwritten; no new slot is used.
  - Exception: count==1 and pop in the same cycle (newest is leaving). No coalesce; a normal enqueue is performed.
- Enqueue (capture, no coalesce):
  - If count < DEPTH, or count == DEPTH and pop this cycle: write at the tail and advance the write pointer.
  - Otherwise (full, no pop): drop the new update; drop_cnt_o increments and saturates at all-ones.
- Simultaneous enqueue and pop: count unchanged.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- flush_i or clr_i:
  - Next cycle: FIFO empty and btb_update_o.valid=0.
  - Any capture or pop in that cycle is suppressed.
  - flush_i leaves drop_cnt_o unchanged; clr_i zeroes it.
- debug_mode_i only blocks capture; already-queued entries still drain.
- update_ready_i low: FIFO holds and valid=0. No timeout.

Decomposition:
- ariane_pkg already defines btb_update_t; no new package typedefs.
- Add localparam BTB_UPDATE_CNT_W = $clog2(DEPTH)+1 inside the module.
- One natural sub-module: btb_update_fifo, a DEPTH-entry FIFO with pointers/count plus a "write newest" port used for coalescing.
- Coalesce/drop/pop control and the output register live in btb_update_gen.

Test Plan:
- Single capture: resolve_pc=0x8000_0010, target=0x8000_0400, ready=1 in cycle 0 -> btb_update_o={1,0x8000_0010,0x8000_0400} in cycle 2 only; pending_o=1 in cycle 1 only.
- Coalesce: ready=0; pc=0x100 with targets 0x200 then 0x300 in consecutive cycles -> count stays 1. Raise ready -> one pulse {pc=0x100, target=0x300}.
- Overflow: ready=0; 5 distinct PCs (0x10, 0x20, 0x30, 0x40, 0x50) with DEPTH=4 -> full_o=1, drop_cnt_o=1. On release, 4 pulses in order 0x10..0x40 on consecutive cycles.
- Full plus pop: FIFO full, ready=1, capture pc=0x60 in the same cycle -> accepted, drop_cnt_o unchanged, count stays 4.
- Flush mid-drain: 3 queued, ready=1, flush_i in cycle of the first pop -> no valid pulse next cycle, pending_o=0, later captures operate normally.
- Filtering: capture with debug_mode_i=1, or with resolve_mispredict_i=0, or with resolve_is_indirect_i=0 -> no entry enqueued. Asynchronous reset mid-drain -> all outputs 0 immediately.
